unpacked_array_deserializer: RTL and testbench
==============================================

Name: unpacked_array_deserializer

Overview:
- Collects a stream of W-bit words and assembles each group of M consecutive words into one frame.
- Presents the frame on an unpacked-array output port, logic [W-1:0] out_data [M], plus a packed mirror of the same frame.
- Inverse of the packing path: the array-port counterpart that feeds unpacked-array consumers.
- Exercises unpacked arrays as module ports under TMR triplication, with real sequential state: counter, FSM and valid/ready handshakes.

Parameters:
- M, 4, number of words per frame (unpacked array size); legal M >= 2.
- W, 8, width of each word in bits; legal W >= 1.

Ports:
- clock  input  1  single clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  W  input word.
- in_sof  input  1  start-of-frame; qualified by in_valid && in_ready.
- out_valid  output  1  frame available on out_data.
- out_ready  input  1  consumer takes the frame.
- out_data  output  W x [M] unpacked  assembled frame; index 0 is the first word received.
- out_packed  output  M*W  packed mirror; word i occupies bits [(M-1-i)*W +: W], so word 0 is MSB-first.
- sof_realign  output  1  one-cycle pulse when in_sof truncates a partial frame.

Behaviour:
- Reset (synchronous, reset==1 at a clock edge) clears state to FILL, count to 0, every out_data[i] to 0, out_packed to 0, out_valid to 0, and sof_realign to 0.
- in_ready is combinational:
  - 1 in FILL;
  - equals out_ready in HOLD.
- A word is accepted when in_valid && in_ready; it is written to buffer[count].
- FSM states are FILL and HOLD.
- FILL:
  - On accept with in_sof==1 and count!=0: the word goes to index 0, count becomes 1, and sof_realign pulses for 1 cycle. Stale words in indices 1..M-1 are not cleared; they are overwritten as the frame refills.
  - On accept with in_sof==1 and count==0: treated as a normal word, no pulse.
  - On accept with count==M-1 and in_sof==0: the word is written to index M-1, count becomes 0, and the next state is HOLD. out_valid rises the cycle after the accept, so latency from the last word to out_valid is 1 cycle.
  - Otherwise count increments.
- HOLD:
  - out_valid=1; out_data and out_packed stay stable until the handshake.
  - On out_valid && out_ready, a simultaneous input accept is allowed. That word goes to index 0 of the next frame and count becomes 1.
  - The next state is FILL, out_valid drops next cycle, and out_data is held at the last frame value.
  - With M words per frame and back-to-back traffic, throughput is one word per cycle.
- out_data is driven from registers: the frame buffer is separate from the output register. The output register loads the complete frame on the FILL->HOLD transition, so out_data never shows a partial frame.
- in_sof during HOLD is honoured only if the word is accepted, i.e. out_ready==1. It then starts the new frame at index 0, with no sof_realign since count was 0.
- Simultaneous completion and in_sof (count==M-1 with in_sof==1): in_sof wins. The word goes to index 0, count becomes 1, sof_realign pulses, and the frame is not emitted.
- Reset mid-frame or in HOLD discards everything. out_valid is 0 on the following cycle, regardless of out_ready.
- Count width is $clog2(M), and it wraps M-1 -> 0 only through the completion path.

Decomposition:
- Shared package unpacked_array_pkg:
  - typedef enum logic {ST_FILL, ST_HOLD} deser_state_t;
  - a localparam function for the count width.
- One sub-module is natural: unpacked_array_register (parameters M, W) for the M x W frame/output register with load enable and synchronous clear.
  - It is reused for both the buffer and the output stage, and keeps unpacked-array ports on internal boundaries too.

Test Plan:
1. M=4, W=8: reset, then send 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1.
   - out_valid=1 one cycle after 0x44.
   - out_data = {0x11,0x22,0x33,0x44}; out_packed = 0x11223344.
   - out_valid drops the next cycle.
2. Backpressure: complete a frame with out_ready=0 for 5 cycles.
   - in_ready=0 and out_data stays stable for all 5 cycles.
   - Then raise out_ready together with in_valid and 0x55: the frame is released the same cycle, 0x55 lands at index 0, and count=1.
3. Realign: send 0xA1,0xA2, then 0xB0 with in_sof=1, then 0xB1,0xB2,0xB3.
   - sof_realign pulses once, on the cycle after 0xB0.
   - The emitted frame is {0xB0,0xB1,0xB2,0xB3}; no frame containing 0xA1 is emitted.
4. Collision: at count==3, send 0xC3 with in_sof=1.
   - No frame is emitted and sof_realign pulses.
   - The next 3 words complete a frame with 0xC3 at index 0.
5. Reset mid-operation: pulse reset after 2 words, and separately during HOLD.
   - out_valid=0 and out_data all zero next cycle.
   - A subsequent full frame emits correctly.
6. Streaming: 64 back-to-back words, out_ready=1 throughout.
   - 16 frames, each with correct order; in_ready never low.
   - A scoreboard checks that out_packed equals the concatenation of out_data.

Source files
------------

// File: rtl/unpacked_array_deserializer_pkg.sv
// unpacked_array_deserializer_pkg: shared types and sizing helpers for the deserializer slice
// Contents: deser_state_t (FILL collects words, HOLD presents a frame), cnt_width() for the word counter
package unpacked_array_pkg;

   typedef enum logic {ST_FILL, ST_HOLD} deser_state_t;

   function automatic int cnt_width(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/unpacked_array_deserializer_if.sv
// unpacked_array_deserializer_if: word stream in, frame (unpacked array + packed mirror) out
// Ports: in_valid/in_ready/in_data/in_sof input stream, out_valid/out_ready/out_data/out_packed frame
//        output, sof_realign pulse; slave = deserializer side, master = producer/consumer side
interface unpacked_array_deserializer_if #(
   parameter int M = 4,
   parameter int W = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic           in_sof;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data [M];
   logic [M*W-1:0] out_packed;
   logic           sof_realign;

   modport slave (
      input  in_valid, in_data, in_sof, out_ready,
      output in_ready, out_valid, out_data, out_packed, sof_realign
   );

   modport master (
      output in_valid, in_data, in_sof, out_ready,
      input  in_ready, out_valid, out_data, out_packed, sof_realign
   );
endinterface

// File: rtl/unpacked_array_deserializer_register.sv
// unpacked_array_register: M x W array register with load enable and synchronous clear
// Ports: clock, clear_i (sync clear, wins over load), load_i, d_i[M] next value, q_o[M] stored value
module unpacked_array_register #(
   parameter int M = 4,
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic [W-1:0] d_i [M],
   output logic [W-1:0] q_o [M]
);

   always_ff @(posedge clock)
      for (int i = 0; i < M; i++)
         if (clear_i) q_o[i] <= '0;
         else if (load_i) q_o[i] <= d_i[i];

endmodule

// File: rtl/unpacked_array_deserializer.sv
// unpacked_array_deserializer: groups M consecutive W-bit words into a frame on an unpacked-array port
// Ports: clock, reset (sync, active-high), bus (slave modport: input stream, frame output, sof_realign)
module unpacked_array_deserializer
   import unpacked_array_pkg::*;
#(
   parameter int M = 4,
   parameter int W = 8
) (
   input logic                        clock,
   input logic                        reset,
   unpacked_array_deserializer_if.slave bus
);

   localparam int CW = cnt_width(M);
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   deser_state_t  state_q, state_d;
   logic [CW-1:0] count_q, count_d, widx;
   logic          realign_q, realign_d;
   logic          accept, complete;
   logic [W-1:0]  buf_q [M];
   logic [W-1:0]  buf_d [M];
   logic [W-1:0]  out_q [M];

   assign bus.in_ready    = (state_q == ST_FILL) || bus.out_ready;
   assign bus.out_valid   = (state_q == ST_HOLD);
   assign bus.sof_realign = realign_q;
   assign bus.out_data    = out_q;

   for (genvar i = 0; i < M; i++) begin : g_pack
      assign bus.out_packed[(M-1-i)*W +: W] = out_q[i];
   end

   // In HOLD the counter is always 0, so an accepted word lands at index 0 and
   // in_sof there can never trigger a realign.
   always_comb begin
      accept    = bus.in_valid && bus.in_ready;
      realign_d = accept && (state_q == ST_FILL) && bus.in_sof && (count_q != '0);
      complete  = accept && (state_q == ST_FILL) && !realign_d && (count_q == LAST);
      widx      = realign_d ? '0 : count_q;
      count_d   = !accept ? count_q : realign_d ? CW'(1) : complete ? '0 : count_q + CW'(1);
      state_d   = (state_q == ST_FILL) ? (complete ? ST_HOLD : ST_FILL)
                                       : (bus.out_ready ? ST_FILL : ST_HOLD);
      buf_d     = buf_q;
      if (accept) buf_d[widx] = bus.in_data;
   end

   always_ff @(posedge clock) begin
      state_q   <= reset ? ST_FILL : state_d;
      count_q   <= reset ? '0 : count_d;
      realign_q <= reset ? 1'b0 : realign_d;
   end

   unpacked_array_register #(.M(M), .W(W)) u_buf (
      .clock   (clock),
      .clear_i (reset),
      .load_i  (accept),
      .d_i     (buf_d),
      .q_o     (buf_q)
   );

   // The output stage takes the buffer's next value so the final word is
   // included, and only loads on completion so a partial frame never shows.
   unpacked_array_register #(.M(M), .W(W)) u_out (
      .clock   (clock),
      .clear_i (reset),
      .load_i  (complete),
      .d_i     (buf_d),
      .q_o     (out_q)
   );

endmodule

// File: tb/tb_unpacked_array_deserializer.sv
// tb_unpacked_array_deserializer: directed plus random stimulus against a queue-based frame model
module tb_unpacked_array_deserializer;
   localparam int M = 4;
   localparam int W = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   unpacked_array_deserializer_if #(.M(M), .W(W)) bus ();

   unpacked_array_deserializer #(.M(M), .W(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] part [$];
   logic [W-1:0] frame_m [M];
   logic         held_m;
   logic         realign_m;

   task automatic check(input string tag, input logic [M*W-1:0] got, input logic [M*W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [M*W-1:0] pack_m();
      logic [M*W-1:0] p = '0;
      for (int i = 0; i < M; i++) p = (p << W) | (M*W)'(frame_m[i]);
      return p;
   endfunction

   task automatic step(input logic v, input logic [W-1:0] d, input logic sof, input logic rdy, input logic rst);
      logic exp_rdy;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_sof    = sof;
      bus.out_ready = rdy;
      reset         = rst;
      #1;
      exp_rdy = !held_m || rdy;
      if (!rst) check("in_ready", (M*W)'(bus.in_ready), (M*W)'(exp_rdy));
      @(posedge clock);
      realign_m = 1'b0;
      if (rst) begin
         part.delete();
         held_m = 1'b0;
         for (int i = 0; i < M; i++) frame_m[i] = '0;
      end else begin
         if (held_m && rdy) held_m = 1'b0;
         if (v && exp_rdy) begin
            if (sof && part.size() != 0) begin
               part.delete();
               realign_m = 1'b1;
            end
            part.push_back(d);
            if (part.size() == M) begin
               for (int i = 0; i < M; i++) frame_m[i] = part[i];
               held_m = 1'b1;
               part.delete();
            end
         end
      end
      #1;
      reset = 1'b0;
      check("out_valid", (M*W)'(bus.out_valid), (M*W)'(held_m));
      check("sof_realign", (M*W)'(bus.sof_realign), (M*W)'(realign_m));
      for (int i = 0; i < M; i++)
         check($sformatf("out_data[%0d]", i), (M*W)'(bus.out_data[i]), (M*W)'(frame_m[i]));
      check("out_packed", bus.out_packed, pack_m());
   endtask

   task automatic word(input logic [W-1:0] d, input logic sof = 1'b0, input logic rdy = 1'b1);
      step(1'b1, d, sof, rdy, 1'b0);
   endtask

   task automatic idle(input logic rdy = 1'b1);
      step(1'b0, '0, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      held_m    = 1'b0;
      realign_m = 1'b0;
      for (int i = 0; i < M; i++) frame_m[i] = '0;
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      idle();

      // basic frame
      word(8'h11); word(8'h22); word(8'h33); word(8'h44);
      check("t1_packed", bus.out_packed, 32'h11223344);
      idle();
      check("t1_valid_drop", (M*W)'(bus.out_valid), '0);

      // backpressure then release with simultaneous accept
      word(8'h01, 1'b0, 1'b0); word(8'h02, 1'b0, 1'b0); word(8'h03, 1'b0, 1'b0); word(8'h04, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) word(8'hEE, 1'b0, 1'b0);
      word(8'h55);
      word(8'h56); word(8'h57); word(8'h58);
      check("t2_packed", bus.out_packed, 32'h55565758);
      idle();

      // realign
      word(8'hA1); word(8'hA2); word(8'hB0, 1'b1); word(8'hB1); word(8'hB2); word(8'hB3);
      check("t3_packed", bus.out_packed, 32'hB0B1B2B3);
      idle();

      // completion colliding with sof
      word(8'hC0); word(8'hC1); word(8'hC2); word(8'hC3, 1'b1);
      word(8'hD1); word(8'hD2); word(8'hD3);
      check("t4_packed", bus.out_packed, 32'hC3D1D2D3);
      idle();

      // reset mid-frame and during HOLD
      word(8'h71); word(8'h72);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      word(8'h81); word(8'h82); word(8'h83); word(8'h84, 1'b0, 1'b0);
      idle(1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      word(8'h91); word(8'h92); word(8'h93); word(8'h94);
      idle();

      // streaming
      for (int k = 0; k < 64; k++) word(W'(k + 1));
      idle();

      // random traffic with occasional resets
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
